pipeline_exec_ctrl: RTL and testbench

//  Execution sequencer for the 5-stage pipeline. Drives the common hold line into the
//  i_step input of every pipeline register (IFID..MEMWB), where hold=1 freezes them.

---
 rtl/pipeline_exec_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_pipeline_exec_ctrl.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_exec_ctrl.sv
// Execution sequencer for the 5-stage pipeline.
// Produces the shared hold line for every pipeline register, the flush pulse,
// the execution-stopped pulse and a saturating count of advanced cycles.
// Accepts CLEAR/RUN/STEP/HALT commands from the debug unit.
// Stops when a HALT instruction reaches MEM/WB.
module pipeline_exec_ctrl #(
  parameter int NB_CNT       = 32,
  parameter int STEP_CYCLES  = 1,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic              clk,
  input  logic              i_reset,
  input  logic              i_cmd_valid,
  input  logic [1:0]        i_cmd,
  output logic              o_cmd_ready,
  input  logic              i_wb_halt,
  output logic              o_hold,
  output logic              o_flush,
  output logic              o_done,
  output logic              o_busy,
  output logic [2:0]        o_state,
  output logic [NB_CNT-1:0] o_cycle_count
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RUN    = 3'd1,
    S_STEP   = 3'd2,
    S_HALTED = 3'd3,
    S_FLUSH  = 3'd4
  } state_t;

  localparam logic [1:0] CMD_CLEAR = 2'b00;
  localparam logic [1:0] CMD_RUN   = 2'b01;
  localparam logic [1:0] CMD_STEP  = 2'b10;
  localparam logic [1:0] CMD_HALT  = 2'b11;

  // Down-counters run from N-1 to 0, so they only need to hold N-1.
  localparam int STEP_W  = (STEP_CYCLES  > 1) ? $clog2(STEP_CYCLES)  : 1;
  localparam int FLUSH_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [STEP_W-1:0]  STEP_LOAD  = STEP_W'(STEP_CYCLES - 1);
  localparam logic [FLUSH_W-1:0] FLUSH_LOAD = FLUSH_W'(FLUSH_CYCLES - 1);

  state_t              state_q, state_d;
  logic [STEP_W-1:0]   step_cnt_q;
  logic [FLUSH_W-1:0]  flush_cnt_q;
  logic [NB_CNT-1:0]   cycle_cnt_q;
  logic                done_q, done_d;
  logic                cmd_accept;
  logic                load_step, load_flush;
  logic                advancing;

  assign cmd_accept = i_cmd_valid & o_cmd_ready;
  // The pipeline moves on exactly the edges where hold is low.
  assign advancing  = (state_q == S_RUN) || (state_q == S_STEP);

  // State register and registered done pulse; reset overrides everything.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (i_reset) begin
      state_q <= S_IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic: command decode, halt detection, step/flush completion.
  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d    = state_q;
    done_d     = 1'b0;
    load_step  = 1'b0;
    load_flush = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cmd_accept) begin
          case (i_cmd)
            CMD_CLEAR: begin
              state_d    = S_FLUSH;
              load_flush = 1'b1;
            end
            CMD_RUN:  state_d = S_RUN;
            CMD_STEP: begin
              state_d   = S_STEP;
              load_step = 1'b1;
            end
            default:  state_d = S_IDLE;  // HALT while idle does nothing
          endcase
        end
      end
      S_RUN: begin
        // A halt instruction takes priority over a simultaneous HALT command.
        if (i_wb_halt) begin
          state_d = S_HALTED;
          done_d  = 1'b1;
        end else if (cmd_accept && (i_cmd == CMD_HALT)) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      S_STEP: begin
        if (i_wb_halt) begin
          state_d = S_HALTED;
          done_d  = 1'b1;
        end else if (step_cnt_q == '0) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      S_HALTED: begin
        if (cmd_accept && (i_cmd == CMD_CLEAR)) begin
          state_d    = S_FLUSH;
          load_flush = 1'b1;
        end
      end
      S_FLUSH: begin
        if (flush_cnt_q == '0) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;  // recover from illegal encodings
    endcase
  end

  // Step and flush down-counters: loaded on entry, decremented while in state.
  always_ff @(posedge clk) begin
    if (i_reset) begin
      step_cnt_q  <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (load_step)
        step_cnt_q <= STEP_LOAD;
      else if ((state_q == S_STEP) && (step_cnt_q != '0))
        step_cnt_q <= step_cnt_q - 1'b1;

      if (load_flush)
        flush_cnt_q <= FLUSH_LOAD;
      else if ((state_q == S_FLUSH) && (flush_cnt_q != '0))
        flush_cnt_q <= flush_cnt_q - 1'b1;
    end
  end

  // Advanced-cycle counter: cleared when CLEAR is taken, saturates at all-ones.
  always_ff @(posedge clk) begin
    if (i_reset)
      cycle_cnt_q <= '0;
    else if (load_flush)
      cycle_cnt_q <= '0;
    else if (advancing && (cycle_cnt_q != '1))
      cycle_cnt_q <= cycle_cnt_q + NB_CNT'(1);
  end

  // Moore outputs decoded from the state register.
  always_comb begin
    o_hold        = 1'b1;
    o_busy        = 1'b0;
    o_flush       = 1'b0;
    o_cmd_ready   = 1'b0;
    o_state       = state_q;
    o_done        = done_q;
    o_cycle_count = cycle_cnt_q;
    case (state_q)
      S_IDLE:   o_cmd_ready = 1'b1;
      S_RUN: begin
        o_hold      = 1'b0;
        o_busy      = 1'b1;
        o_cmd_ready = 1'b1;
      end
      S_STEP: begin
        o_hold = 1'b0;
        o_busy = 1'b1;
      end
      S_HALTED: o_cmd_ready = 1'b1;
      S_FLUSH:  o_flush     = 1'b1;
      default:  o_hold      = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_pipeline_exec_ctrl.sv
// Testbench for pipeline_exec_ctrl.
// Two instances: default parameters, and a narrow-counter, four-edge-step variant.
// Expected snapshots and done events are queued by the stimulus.
// A negedge monitor pops and compares them.
module tb_pipeline_exec_ctrl;

  localparam logic [2:0] IDLE = 3'd0, RUN = 3'd1, STEP = 3'd2, HALTED = 3'd3, FLUSH = 3'd4;
  localparam logic [1:0] C_CLEAR = 2'b00, C_RUN = 2'b01, C_STEP = 2'b10, C_HALT = 2'b11;

  typedef struct {
    logic [2:0]  state;
    logic [31:0] count;
    logic        hold, flush, ready, busy, done;
  } snap_t;

  typedef struct {
    logic [2:0]  state;
    logic [31:0] count;
  } done_t;

  logic clk = 1'b0;
  logic reset, sel, cmd_valid, wb_halt;
  logic [1:0] cmd;

  // instance A outputs
  logic a_ready, a_hold, a_flush, a_done, a_busy;
  logic [2:0] a_state;
  logic [31:0] a_count;
  // instance B outputs
  logic b_ready, b_hold, b_flush, b_done, b_busy;
  logic [2:0] b_state;
  logic [3:0] b_count;

  int checks = 0;
  int errors = 0;

  snap_t snap_q[$];
  string snap_tag_q[$];
  done_t done_q[$];
  string done_tag_q[$];

  always #5 clk = ~clk;

  pipeline_exec_ctrl #(.NB_CNT(32), .STEP_CYCLES(1), .FLUSH_CYCLES(2)) dut_a (
    .clk(clk), .i_reset(reset),
    .i_cmd_valid(cmd_valid & ~sel), .i_cmd(cmd), .o_cmd_ready(a_ready),
    .i_wb_halt(wb_halt & ~sel),
    .o_hold(a_hold), .o_flush(a_flush), .o_done(a_done), .o_busy(a_busy),
    .o_state(a_state), .o_cycle_count(a_count)
  );

  pipeline_exec_ctrl #(.NB_CNT(4), .STEP_CYCLES(4), .FLUSH_CYCLES(2)) dut_b (
    .clk(clk), .i_reset(reset),
    .i_cmd_valid(cmd_valid & sel), .i_cmd(cmd), .o_cmd_ready(b_ready),
    .i_wb_halt(wb_halt & sel),
    .o_hold(b_hold), .o_flush(b_flush), .o_done(b_done), .o_busy(b_busy),
    .o_state(b_state), .o_cycle_count(b_count)
  );

  // Observed instance selected by sel.
  logic        m_ready, m_hold, m_flush, m_done, m_busy;
  logic [2:0]  m_state;
  logic [31:0] m_count;
  assign m_ready = sel ? b_ready : a_ready;
  assign m_hold  = sel ? b_hold  : a_hold;
  assign m_flush = sel ? b_flush : a_flush;
  assign m_done  = sel ? b_done  : a_done;
  assign m_busy  = sel ? b_busy  : a_busy;
  assign m_state = sel ? b_state : a_state;
  assign m_count = sel ? {28'd0, b_count} : a_count;

  // Expected Moore outputs for a given state, from the state table.
  function automatic snap_t mk(input logic [2:0] st, input int cnt, input logic dn);
    snap_t s;
    s.state = st;
    s.count = cnt;
    s.hold  = !((st == RUN) || (st == STEP));
    s.busy  = (st == RUN) || (st == STEP);
    s.flush = (st == FLUSH);
    s.ready = (st == IDLE) || (st == RUN) || (st == HALTED);
    s.done  = dn;
    return s;
  endfunction

  task automatic expect_snap(input string tag, input logic [2:0] st, input int cnt, input logic dn);
    snap_q.push_back(mk(st, cnt, dn));
    snap_tag_q.push_back(tag);
  endtask

  task automatic expect_done(input string tag, input logic [2:0] st, input int cnt);
    done_t d;
    d.state = st;
    d.count = cnt;
    done_q.push_back(d);
    done_tag_q.push_back(tag);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] c);
    cmd_valid = 1'b1;
    cmd = c;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic do_clear(input string tag);
    send(C_CLEAR);
    expect_snap({tag, "_flush1"}, FLUSH, 0, 1'b0);
    tick();
    expect_snap({tag, "_flush2"}, FLUSH, 0, 1'b0);
    tick();
    expect_snap({tag, "_idle"}, IDLE, 0, 1'b0);
  endtask

  // Monitor: compares done events and queued snapshots in the low clock phase.
  snap_t e;
  done_t d;
  string t;
  always @(negedge clk) begin
    if (m_done === 1'b1) begin
      checks++;
      if (done_q.size() == 0) begin
        errors++;
        $display("FAIL done_unexpected: got done with state=%0d count=%0d, required no done",
                 m_state, m_count);
      end else begin
        d = done_q.pop_front();
        t = done_tag_q.pop_front();
        if (m_state !== d.state || m_count !== d.count) begin
          errors++;
          $display("FAIL %s: done with state=%0d count=%0d, required state=%0d count=%0d",
                   t, m_state, m_count, d.state, d.count);
        end
      end
    end
    while (snap_q.size() > 0) begin
      e = snap_q.pop_front();
      t = snap_tag_q.pop_front();
      checks++;
      if (m_state !== e.state || m_count !== e.count || m_hold !== e.hold ||
          m_flush !== e.flush || m_cmd_ok(e) || m_busy !== e.busy || m_done !== e.done) begin
        errors++;
        $display("FAIL %s: got st=%0d cnt=%0d hold=%b flush=%b rdy=%b busy=%b done=%b, required st=%0d cnt=%0d hold=%b flush=%b rdy=%b busy=%b done=%b",
                 t, m_state, m_count, m_hold, m_flush, m_ready, m_busy, m_done,
                 e.state, e.count, e.hold, e.flush, e.ready, e.busy, e.done);
      end
    end
  end

  function automatic logic m_cmd_ok(input snap_t s);
    return (m_ready !== s.ready);
  endfunction

  initial begin
    logic [1:0] drop_cmds [4];
    drop_cmds[0] = C_CLEAR; drop_cmds[1] = C_HALT; drop_cmds[2] = C_RUN; drop_cmds[3] = C_CLEAR;
    reset = 1'b1; sel = 1'b0; cmd_valid = 1'b0; cmd = 2'b00; wb_halt = 1'b0;

    // 1: reset held three cycles, then released
    repeat (3) tick();
    expect_snap("reset_held", IDLE, 0, 1'b0);
    reset = 1'b0;
    tick();
    expect_snap("reset_release", IDLE, 0, 1'b0);

    // 2: single steps, hold low for exactly one cycle each
    for (int i = 1; i <= 3; i++) begin
      expect_done("step_done_evt", IDLE, i);
      send(C_STEP);
      expect_snap("step_active", STEP, i - 1, 1'b0);
      tick();
      expect_snap("step_done", IDLE, i, 1'b1);
      tick();
      expect_snap("step_idle", IDLE, i, 1'b0);
    end

    // Clear so the run starts from zero
    do_clear("clr0");

    // 3: run, halt instruction after seven advances
    send(C_RUN);
    repeat (7) tick();
    expect_snap("run7", RUN, 7, 1'b0);
    expect_done("wb_halt_evt", HALTED, 8);
    wb_halt = 1'b1;
    tick();
    wb_halt = 1'b0;
    expect_snap("wb_halted", HALTED, 8, 1'b1);
    send(C_RUN);
    send(C_STEP);
    wb_halt = 1'b1;
    tick();
    wb_halt = 1'b0;
    tick();
    expect_snap("halted_ignore", HALTED, 8, 1'b0);
    do_clear("clr1");

    // RUN consumes CLEAR without effect; HALT command stops to IDLE
    send(C_RUN);
    tick();
    send(C_CLEAR);
    expect_snap("run_clear_ignored", RUN, 2, 1'b0);
    expect_done("halt_cmd_evt", IDLE, 3);
    send(C_HALT);
    expect_snap("halt_cmd_idle", IDLE, 3, 1'b1);

    // 4: HALT command and halt instruction on the same edge
    send(C_RUN);
    tick();
    expect_done("both_halt_evt", HALTED, 5);
    cmd_valid = 1'b1; cmd = C_HALT; wb_halt = 1'b1;
    tick();
    cmd_valid = 1'b0; wb_halt = 1'b0;
    expect_snap("both_halt", HALTED, 5, 1'b1);
    do_clear("clr2");

    // 5: HALT ignored in IDLE; reset mid-run
    send(C_HALT);
    expect_snap("idle_halt_ignored", IDLE, 0, 1'b0);
    send(C_RUN);
    repeat (5) tick();
    expect_snap("run5", RUN, 5, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    expect_snap("mid_reset", IDLE, 0, 1'b0);
    tick();
    expect_snap("post_reset", IDLE, 0, 1'b0);

    // 6: four-edge step on instance B with commands dropped meanwhile
    sel = 1'b1;
    expect_done("step4_evt", IDLE, 4);
    send(C_STEP);
    expect_snap("step4_start", STEP, 0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cmd_valid = 1'b1;
      cmd = drop_cmds[i];
      tick();
      if (i < 3) expect_snap("step4_mid", STEP, i + 1, 1'b0);
    end
    cmd_valid = 1'b0;
    expect_snap("step4_end", IDLE, 4, 1'b1);

    // halt instruction during a multi-edge step
    expect_done("step_wb_evt", HALTED, 6);
    send(C_STEP);
    tick();
    wb_halt = 1'b1;
    tick();
    wb_halt = 1'b0;
    expect_snap("step_wb_halt", HALTED, 6, 1'b1);
    do_clear("clr3");

    // saturation of the 4-bit counter
    send(C_RUN);
    repeat (15) tick();
    expect_snap("sat15", RUN, 15, 1'b0);
    repeat (5) tick();
    expect_snap("sat20", RUN, 15, 1'b0);
    expect_done("sat_halt_evt", IDLE, 15);
    send(C_HALT);
    expect_snap("sat_halt", IDLE, 15, 1'b1);

    repeat (3) tick();
    checks++;
    if (done_q.size() != 0 || snap_q.size() != 0) begin
      errors++;
      $display("FAIL queues_drained: got %0d done and %0d snapshots pending, required 0 and 0",
               done_q.size(), snap_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: simulation still running at 200000, required completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
